fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side master for the team's synchronous FIFO. On a start command it drains exactly burst_len words through the FIFO's cs/rd_en/empty/data_out read port and presents them on a valid/ready stream output.
- The FIFO registers data_out one cycle after an accepted read. This block absorbs that latency with a 2-entry skid buffer, so it sustains 1 word/cycle under continuous m_ready.
- It sits between a FIFO instance and any downstream consumer, such as a serializer or DMA sink.

Parameters:
- DATA_width, 32, word width; must equal the FIFO's DATA_width.
- LEN_width, 8, width of burst_len and the word counters; max burst = 2^LEN_width-1.

Ports:
- clk  input  1  rising-edge clock, shared with the FIFO.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  one-cycle pulse; begins a burst when idle.
- burst_len  input  LEN_width  number of words to transfer; sampled on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last word is accepted downstream.
- words_sent  output  LEN_width  words accepted downstream in the current/last burst.
- fifo_cs  output  1  FIFO chip select; equal to fifo_rd_en.
- fifo_rd_en  output  1  FIFO read request.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_width  FIFO data_out; valid the cycle after an issued read.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_width  stream word.

Behaviour:
- Reset values (async, rst_n=0): state IDLE, busy=0, done=0, fifo_rd_en=0, fifo_cs=0, m_valid=0, m_data=0, words_sent=0, skid occupancy=0, in-flight flag=0, issued count=0.
- States:
  - IDLE: on start, latch burst_len and clear issued and words_sent. If burst_len=0, go to FINISH; else go to RUN.
  - RUN: issue reads and deliver words. When words_sent+pop reaches burst_len, go to FINISH.
  - FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
- start is ignored in RUN and FINISH.
- Read issue (combinational):
  - fifo_rd_en = (state==RUN) & ~fifo_empty & (issued < len) & (occ + inflight - pop < 2), where pop = m_valid & m_ready.
  - The m_ready-to-fifo_rd_en combinational path is intended; it is required for 1 word/cycle throughput.
- In-flight tracking:
  - inflight is set at the edge where fifo_rd_en=1.
  - At the next edge, fifo_data is written into the skid buffer.
  - issued increments on each issued read.
- Skid buffer:
  - 2-entry FIFO; m_data/m_valid are driven from the head entry.
  - Order is strictly preserved.
  - While m_valid=1 and m_ready=0, m_data is held stable.
  - The buffer never overflows: occ + inflight <= 2 always. Verification asserts this.
- Simultaneous push and pop: occupancy unchanged, head advances.
- FIFO empty mid-burst: no read is issued, and the burst stalls indefinitely. There is no timeout. m_valid drops once the buffer is drained.
- Backpressure: m_ready=0 for any length stalls reads once occ+inflight=2. No data is lost or duplicated.
- Counter width: words_sent and issued are LEN_width bits and never wrap within a burst, because burst_len <= 2^LEN_width-1. words_sent holds its final value after done until the next accepted start.
- busy=1 in RUN only.
- Reset mid-burst:
  - All state clears immediately.
  - A word in flight or buffered is discarded. The FIFO read pointer has already advanced, so that data is lost by design.
  - Software must reset the FIFO together with this block.

Test Plan:
- Basic burst: FIFO preloaded 0x11..0x15, start with burst_len=5, m_ready=1 → m_data 0x11,0x12,0x13,0x14,0x15 on 5 consecutive cycles; first m_valid 2 cycles after the first fifo_rd_en; done pulses once; words_sent=5; FIFO empty=1.
- Zero length: start with burst_len=0 → no fifo_rd_en; done one cycle later; words_sent=0.
- Backpressure: 6 words, burst_len=6, m_ready toggling 1,0,0,1,... → occ+inflight never exceeds 2; m_data held during stalls; output sequence identical to FIFO contents.
- Starvation: burst_len=4 with only 2 words in the FIFO → 2 words out, then busy stays 1 with no rd_en while empty. Write 2 more → remaining 2 delivered, then done.
- Start while busy: second start pulse mid-burst with burst_len=9 → ignored; burst completes with the original length.
- Reset mid-burst: rst_n low for 1 cycle after 3 of 8 words → all outputs return to reset values asynchronously, busy=0. A new start with burst_len=2 operates normally.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: drains burst_len words through the
// FIFO read port and presents them on a valid/ready stream via a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int DATA_width = 32,
  parameter int LEN_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_width-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_width-1:0]  words_sent,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_width-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_width-1:0] m_data,
  output logic [1:0]            dbg_state
);

  // Stream handshake: a word transfers on every rising edge where m_valid and
  // m_ready are both high; m_data is held stable while m_valid=1 and m_ready=0.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                state_q, state_nxt;
  logic [LEN_width-1:0]  len_q;
  logic [LEN_width-1:0]  issued_q;
  logic [LEN_width-1:0]  words_q;
  logic                  inflight_q;
  logic [DATA_width-1:0] skid_q [2];
  logic                  head_q;
  logic [1:0]            occ_q;

  logic                  pop;
  logic                  push;
  logic                  tail;
  logic                  room;
  logic                  rd_en;
  logic                  accept_start;
  logic [1:0]            pending;
  logic [LEN_width-1:0]  sent_after_pop;

  // Reads already issued but not yet delivered must never exceed the two skid slots.
  always_comb begin
    pop            = m_valid & m_ready;
    push           = inflight_q;
    tail           = head_q ^ occ_q[0];
    pending        = occ_q + {1'b0, inflight_q};
    room           = (pending < 2'd2) | ((pending == 2'd2) & pop);
    rd_en          = (state_q == RUN) & ~fifo_empty & (issued_q < len_q) & room;
    sent_after_pop = words_q + {{(LEN_width-1){1'b0}}, pop};
  end

  always_comb begin
    state_nxt    = state_q;
    accept_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = (burst_len == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (sent_after_pop == len_q) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      words_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      inflight_q <= rd_en;
      if (accept_start) begin
        len_q    <= burst_len;
        issued_q <= '0;
        words_q  <= '0;
      end else begin
        if (rd_en) issued_q <= issued_q + 1'b1;
        if (pop)   words_q  <= words_q + 1'b1;
      end
    end
  end

  // Skid buffer: the FIFO's registered data_out lands one edge after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      head_q    <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push) skid_q[tail] <= fifo_data;
      if (pop) head_q <= ~head_q;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = skid_q[head_q];
  assign fifo_rd_en = rd_en;
  assign fifo_cs    = rd_en;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == FINISH);
  assign words_sent = words_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model and a
// scoreboard monitor comparing every accepted stream word against exp_q.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done, fifo_cs, fifo_rd_en, fifo_empty, m_valid;
  logic          m_ready = 1'b1;
  logic [LW-1:0] words_sent;
  logic [DW-1:0] fifo_data, m_data;
  logic [1:0]    dbg_state;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  fifo_stream_reader #(.DATA_width(DW), .LEN_width(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .words_sent(words_sent),
    .fifo_cs(fifo_cs), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Behavioural FIFO with registered data_out
  logic [DW-1:0] fmem [0:15];
  logic [3:0]    fw, fr;
  int            fcount;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw <= '0; fr <= '0; fcount <= 0; fifo_data <= '0;
    end else begin
      if (wr_en) begin
        fmem[fw] <= wr_data;
        fw <= fw + 4'd1;
      end
      if (fifo_rd_en && fcount > 0) begin
        fifo_data <= fmem[fr];
        fr <= fr + 4'd1;
      end
      fcount <= fcount + (wr_en ? 1 : 0) - ((fifo_rd_en && fcount > 0) ? 1 : 0);
    end
  end
  assign fifo_empty = (fcount == 0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge
  int          done_cnt = 0;
  int          rd_total = 0;
  int          outstanding = 0;
  logic        held_valid = 1'b0;
  logic [DW-1:0] held_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      held_valid  = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (fifo_rd_en) rd_total++;
      if (fifo_cs !== fifo_rd_en) check("cs_eq_rd_en", fifo_cs, fifo_rd_en);
      if (fifo_rd_en) check("occ_plus_inflight_le2",
                            (outstanding + 1 - ((m_valid && m_ready) ? 1 : 0)) <= 2, 1);
      outstanding = outstanding + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (m_valid && held_valid) check("stall_hold", m_data, held_data);
      if (m_valid && m_ready) begin
        held_valid = 1'b0;
        if (exp_q.size() == 0) check("spurious_word", m_data, 64'hDEAD_0000);
        else check("stream_word", m_data, exp_q.pop_front());
      end else if (m_valid) begin
        held_valid = 1'b1;
        held_data  = m_data;
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  // Driver tasks: inputs change #1 after the rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [LW-1:0] len);
    start = 1'b1; burst_len = len;
    tick();
    start = 1'b0;
  endtask

  // mode 1 drives m_ready with the repeating pattern 1,0,0,1
  task automatic run_until_done(input int mode, input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      m_ready = (mode == 0) ? 1'b1 : (((k % 4) == 0) || ((k % 4) == 3));
      tick();
      if (done_cnt != d0) seen = 1;
    end
    m_ready = 1'b1;
    check("done_within_budget", seen, 1);
  endtask

  initial begin
    int d0, r0, first_rd, first_val, last_val, nval;
    bit got;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_words_sent", words_sent, 0);
    rst_n = 1'b1;
    tick();

    // Basic burst of 5 with continuous m_ready
    for (int i = 0; i < 5; i++) wr(DW'(32'h11 + i));
    d0 = done_cnt;
    pulse_start(8'd5);
    first_rd = -1; first_val = -1; last_val = -1; nval = 0; got = 0;
    for (int j = 0; j < 30 && !got; j++) begin
      if (fifo_rd_en && first_rd < 0) first_rd = j;
      if (m_valid) begin
        if (first_val < 0) first_val = j;
        last_val = j;
        nval++;
      end
      if (done) got = 1;
      else tick();
    end
    check("basic_done_seen", got, 1);
    check("basic_first_valid_latency", first_val - first_rd, 2);
    check("basic_valid_count", nval, 5);
    check("basic_back_to_back", last_val - first_val, 4);
    tick();
    check("basic_done_pulses", done_cnt - d0, 1);
    check("basic_words_sent", words_sent, 5);
    check("basic_fifo_empty", fifo_empty, 1);
    check("basic_busy_low", busy, 0);

    // Zero-length burst
    r0 = rd_total;
    pulse_start(8'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_words_sent", words_sent, 0);
    tick();
    check("zero_done_one_cycle", done, 0);
    check("zero_no_reads", rd_total - r0, 0);

    // Backpressure with m_ready 1,0,0,1,...
    for (int i = 0; i < 6; i++) wr(DW'(32'hA0 + i));
    pulse_start(8'd6);
    run_until_done(1, 100);
    check("bp_words_sent", words_sent, 6);
    check("bp_queue_drained", exp_q.size(), 0);

    // Starvation: 4-word burst with only 2 words available
    wr(32'h31); wr(32'h32);
    r0 = rd_total;
    pulse_start(8'd4);
    repeat (15) tick();
    check("starve_words_sent", words_sent, 2);
    check("starve_busy", busy, 1);
    check("starve_reads", rd_total - r0, 2);
    check("starve_m_valid", m_valid, 0);
    wr(32'h33); wr(32'h34);
    run_until_done(0, 50);
    check("starve_words_final", words_sent, 4);

    // Second start during a burst is ignored
    for (int i = 0; i < 3; i++) wr(DW'(32'h41 + i));
    d0 = done_cnt; r0 = rd_total;
    pulse_start(8'd3);
    pulse_start(8'd9);
    run_until_done(0, 50);
    check("busy_start_words", words_sent, 3);
    repeat (5) tick();
    check("busy_start_idle", busy, 0);
    check("busy_start_done_once", done_cnt - d0, 1);
    check("busy_start_reads", rd_total - r0, 3);

    // Reset after 3 of 8 words
    for (int i = 0; i < 8; i++) wr(DW'(32'h51 + i));
    pulse_start(8'd8);
    got = 0;
    for (int j = 0; j < 40 && !got; j++) begin
      if (words_sent == 8'd3) got = 1;
      else tick();
    end
    check("rstmid_reached_3", got, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_m_valid", m_valid, 0);
    check("rstmid_m_data", m_data, 0);
    check("rstmid_rd_en", fifo_rd_en, 0);
    check("rstmid_words_sent", words_sent, 0);
    tick();
    rst_n = 1'b1;
    tick();
    wr(32'h61); wr(32'h62);
    d0 = done_cnt;
    pulse_start(8'd2);
    run_until_done(0, 50);
    check("post_rst_words", words_sent, 2);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_drained", exp_q.size(), 0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
